// File: rtl/wb_loader_regs.sv
// Wishbone register block between the management SoC and the jacaranda-8 core.
// Provides the instruction-memory write port, the UART frequency, CPU reset control, status and scratch registers.
module wb_loader_regs #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned IMEM_AW       = 8,
    parameter int unsigned IMEM_DW       = 8,
    parameter int unsigned NUM_SCRATCH   = 2,
    parameter logic [31:0] UART_FREQ_RST = 32'd50_000_000,
    parameter logic        CPU_RST_INIT  = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [IMEM_AW-1:0] instr_mem_addr,
    output logic [IMEM_DW-1:0] instr_mem_data,
    output logic               instr_mem_en,
    output logic [31:0]        uart_freq,
    output logic               cpu_rst_o
);

    localparam int unsigned SCR_N = (NUM_SCRATCH == 0) ? 1 : NUM_SCRATCH;

    localparam logic [5:0] OFF_DIRECT = 6'h00;
    localparam logic [5:0] OFF_UART   = 6'h01;
    localparam logic [5:0] OFF_PTR    = 6'h02;
    localparam logic [5:0] OFF_STREAM = 6'h03;
    localparam logic [5:0] OFF_CTRL   = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h05;
    localparam logic [5:0] OFF_SCR0   = 6'h06;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [IMEM_AW-1:0] ptr;
    logic [15:0]        cnt;
    logic               autoinc;
    logic [31:0]        scratch [SCR_N];

    logic               accept;
    logic               hit;
    logic               wr_en;
    logic [5:0]         offset;
    logic [SCR_N-1:0]   scr_sel;
    logic [31:0]        rdata;
    logic               unused_bits;

    // A new request is taken only while ack is low, which spaces transfers two cycles apart.
    assign accept      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign hit         = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset      = wbs_adr_i[7:2];
    assign wr_en       = accept & hit & wbs_we_i;
    assign unused_bits = ^wbs_adr_i[1:0];

    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Scratch slots that exist and match the current offset.
    always_comb begin
        scr_sel = '0;
        for (int unsigned i = 0; i < SCR_N; i++) begin
            scr_sel[i] = (i < NUM_SCRATCH) && (offset == 6'(32'(OFF_SCR0) + i));
        end
    end

    // Readback mux; write-only, unmapped and missed addresses read as zero.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_UART:   rdata = uart_freq;
                OFF_PTR:    rdata = 32'(ptr);
                OFF_CTRL:   rdata = {30'd0, autoinc, cpu_rst_o};
                OFF_STATUS: rdata = {16'(ptr), cnt};
                default: begin
                    for (int unsigned i = 0; i < SCR_N; i++) begin
                        if (scr_sel[i]) begin
                            rdata = scratch[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            instr_mem_addr <= '0;
            instr_mem_data <= '0;
            instr_mem_en   <= 1'b0;
            uart_freq      <= UART_FREQ_RST;
            cpu_rst_o      <= CPU_RST_INIT;
            ptr            <= '0;
            cnt            <= '0;
            autoinc        <= 1'b1;
            for (int unsigned i = 0; i < SCR_N; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            wbs_ack_o    <= accept;
            wbs_dat_o    <= (accept && !wbs_we_i) ? rdata : 32'd0;
            instr_mem_en <= 1'b0;
            if (wr_en) begin
                case (offset)
                    OFF_DIRECT: begin
                        instr_mem_addr <= wbs_dat_i[IMEM_DW+IMEM_AW-1:IMEM_DW];
                        instr_mem_data <= wbs_dat_i[IMEM_DW-1:0];
                        instr_mem_en   <= 1'b1;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    OFF_UART: begin
                        uart_freq <= merge_lanes(uart_freq, wbs_dat_i, wbs_sel_i);
                    end
                    OFF_PTR: begin
                        if (wbs_sel_i[0]) begin
                            ptr <= wbs_dat_i[IMEM_AW-1:0];
                        end
                    end
                    OFF_STREAM: begin
                        instr_mem_addr <= ptr;
                        instr_mem_data <= wbs_dat_i[IMEM_DW-1:0];
                        instr_mem_en   <= 1'b1;
                        // Pointer wraps silently at 2^IMEM_AW.
                        if (autoinc) begin
                            ptr <= ptr + IMEM_AW'(1);
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    OFF_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            cpu_rst_o <= wbs_dat_i[0];
                            autoinc   <= wbs_dat_i[1];
                        end
                    end
                    default: begin
                        for (int unsigned i = 0; i < SCR_N; i++) begin
                            if (scr_sel[i]) begin
                                scratch[i] <= merge_lanes(scratch[i], wbs_dat_i, wbs_sel_i);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_loader_regs.sv
// Self-checking bench for wb_loader_regs: directed vector table, multi-cycle corner
// sequences, then random traffic compared against a register-map model.
module tb_wb_loader_regs;

    localparam int unsigned NS = 2;
    localparam logic [31:0] UART_DEF = 32'h02FA_F080;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  ia, id;
    logic        en;
    logic [31:0] uart;
    logic        cpu_rst;

    always #5 clk = ~clk;

    wb_loader_regs #(
        .BASE_ADDR(32'h3000_0000), .IMEM_AW(8), .IMEM_DW(8), .NUM_SCRATCH(NS),
        .UART_FREQ_RST(UART_DEF), .CPU_RST_INIT(1'b1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .instr_mem_addr(ia), .instr_mem_data(id), .instr_mem_en(en),
        .uart_freq(uart), .cpu_rst_o(cpu_rst)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_uart;
    int          m_ptr;
    int          m_cnt;
    bit          m_auto, m_rst;
    logic [31:0] m_scr [NS];
    logic [7:0]  m_ia, m_id;

    task automatic model_reset();
        m_uart = UART_DEF; m_ptr = 0; m_cnt = 0; m_auto = 1; m_rst = 1;
        m_ia = 0; m_id = 0;
        for (int i = 0; i < NS; i++) m_scr[i] = 0;
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] nv,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nv[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        if (a[31:8] != 24'h300000) return 0;
        w = int'(a[7:2]);
        case (w)
            1: return m_uart;
            2: return 32'(m_ptr);
            4: return 32'(m_rst) + 32'(m_auto) * 2;
            5: return 32'(m_ptr) * 65536 + 32'(m_cnt);
            default: if (w >= 6 && w < 6 + NS) return m_scr[w-6];
        endcase
        return 0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output bit exp_en);
        int w;
        exp_en = 0;
        if (a[31:8] != 24'h300000) return;
        w = int'(a[7:2]);
        case (w)
            0: begin m_ia = d[15:8]; m_id = d[7:0]; exp_en = 1; end
            1: m_uart = lanes(m_uart, d, s);
            2: if (s[0]) m_ptr = int'(d[7:0]);
            3: begin
                m_ia = 8'(m_ptr); m_id = d[7:0]; exp_en = 1;
                if (m_auto) m_ptr = (m_ptr + 1) % 256;
            end
            4: if (s[0]) begin m_rst = d[0]; m_auto = d[1]; end
            default: if (w >= 6 && w < 6 + NS) m_scr[w-6] = lanes(m_scr[w-6], d, s);
        endcase
        if (exp_en && m_cnt < 65535) m_cnt++;
    endtask

    // ---------------- bus helpers ----------------
    // Entered just after a falling edge; returns values seen in the ack cycle.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic en1,
                        output logic [7:0] ia1, output logic [7:0] id1, output logic rst1);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        check("ack_rise", 32'(ack), 1);
        rd = rdat; en1 = en; ia1 = ia; id1 = id; rst1 = cpu_rst;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        check("ack_fall", 32'(ack), 0);
        check("en_fall", 32'(en), 0);
        check("dat_idle", rdat, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cyc = 0; stb = 0; we = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        logic [31:0] exp_rd, rd;
        logic        en1, rst1;
        logic [7:0]  ia1, id1;
        bit          exp_en;
        exp_rd = w ? 32'd0 : model_read(a);
        exp_en = 0;
        xfer(w, a, d, s, rd, en1, ia1, id1, rst1);
        if (w) model_write(a, d, s, exp_en);
        else check("rnd_rdata", rd, exp_rd);
        check("rnd_en", 32'(en1), 32'(exp_en));
        if (exp_en) begin
            check("rnd_iaddr", 32'(ia1), 32'(m_ia));
            check("rnd_idata", 32'(id1), 32'(m_id));
        end
        check("rnd_cpu_rst", 32'(rst1), 32'(m_rst));
        check("rnd_uart", uart, m_uart);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rd;
        bit          en;
        logic [7:0]  ia;
        logic [7:0]  id;
        bit          rst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] r, input bit e,
                                input logic [7:0] xa, input logic [7:0] xd, input bit cr);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.sel = s; v.rd = r;
        v.en = e; v.ia = xa; v.id = xd; v.rst = cr;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        en1, rst1;
        logic [7:0]  ia1, id1;
        logic [7:0]  offs [12];

        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        model_reset();

        tbl.push_back(mk(0, 32'h3000_0004, 0, 4'hF, 32'h02FA_F080, 0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h3000_0010, 0, 4'hF, 32'h0000_0003, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_0000, 32'h12AB, 4'hF, 0, 1, 8'h12, 8'hAB, 1));
        tbl.push_back(mk(0, 32'h3000_0014, 0, 4'hF, 32'h0000_0001, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_0008, 32'hFE, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_000C, 32'h11, 4'hF, 0, 1, 8'hFE, 8'h11, 1));
        tbl.push_back(mk(1, 32'h3000_000C, 32'h22, 4'hF, 0, 1, 8'hFF, 8'h22, 1));
        tbl.push_back(mk(1, 32'h3000_000C, 32'h33, 4'hF, 0, 1, 8'h00, 8'h33, 1));
        tbl.push_back(mk(0, 32'h3000_0014, 0, 4'hF, 32'h0001_0004, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_0010, 32'h1, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_000C, 32'h44, 4'hF, 0, 1, 8'h01, 8'h44, 1));
        tbl.push_back(mk(1, 32'h3000_000C, 32'h55, 4'h0, 0, 1, 8'h01, 8'h55, 1));
        tbl.push_back(mk(0, 32'h3000_0014, 0, 4'hF, 32'h0001_0006, 0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h3000_0010, 0, 4'hF, 32'h0000_0001, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h3000_0010, 32'h2, 4'h1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0004, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0004, 0, 4'hF, 32'h02BB_F0DD, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0030, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0100, 0, 4'hF, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0030, 0, 4'hF, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0004, 0, 4'hF, 32'h02BB_F0DD, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0018, 32'hDEAD_BEEF, 4'b1100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0018, 0, 4'hF, 32'hDEAD_0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_001C, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_001C, 0, 4'hF, 32'h1234_5678, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0020, 0, 4'hF, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0014, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0014, 0, 4'hF, 32'h0001_0006, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0000, 0, 4'hF, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_000C, 0, 4'hF, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3000_0008, 32'h77, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0008, 0, 4'hF, 32'h0000_0001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000_0010, 0, 4'hF, 32'h0000_0002, 0, 0, 0, 0));

        do_reset();
        check("rst_ack", 32'(ack), 0);
        check("rst_dat", rdat, 0);
        check("rst_en", 32'(en), 0);
        check("rst_iaddr", 32'(ia), 0);
        check("rst_idata", 32'(id), 0);
        check("rst_uart", uart, UART_DEF);
        check("rst_cpu_rst", 32'(cpu_rst), 1);

        foreach (tbl[k]) begin
            xfer(tbl[k].we, tbl[k].adr, tbl[k].dat, tbl[k].sel, rd, en1, ia1, id1, rst1);
            if (!tbl[k].we) check($sformatf("vec%0d_rdata", k), rd, tbl[k].rd);
            check($sformatf("vec%0d_en", k), 32'(en1), 32'(tbl[k].en));
            if (tbl[k].en) begin
                check($sformatf("vec%0d_iaddr", k), 32'(ia1), 32'(tbl[k].ia));
                check($sformatf("vec%0d_idata", k), 32'(id1), 32'(tbl[k].id));
            end
            check($sformatf("vec%0d_cpu_rst", k), 32'(rst1), 32'(tbl[k].rst));
        end
        check("vec_uart_out", uart, 32'h02BB_F0DD);

        // Reset coinciding with a request: the request is dropped.
        @(negedge clk);
        rst = 1; cyc = 1; stb = 1; we = 1; adr = 32'h3000_000C; wdat = 32'h99; sel = 4'hF;
        @(posedge clk); #1;
        check("rstreq_ack", 32'(ack), 0);
        check("rstreq_en", 32'(en), 0);
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0; we = 0;
        model_reset();
        do_txn(0, 32'h3000_0014, 0, 4'hF);
        do_txn(0, 32'h3000_0010, 0, 4'hF);
        do_txn(0, 32'h3000_0018, 0, 4'hF);
        check("rstreq_uart", uart, UART_DEF);

        // cyc/stb held high: ack alternates and never locks up.
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0004; sel = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_ack", k), 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold%0d_dat", k), rdat, (k % 2 == 0) ? UART_DEF : 32'd0);
        end
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);

        // Reset while the imem strobe is high.
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_000C; wdat = 32'h5A; sel = 4'hF;
        @(posedge clk); #1;
        check("rsten_en_hi", 32'(en), 1);
        check("rsten_ack_hi", 32'(ack), 1);
        rst = 1; cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        check("rsten_en_lo", 32'(en), 0);
        check("rsten_ack_lo", 32'(ack), 0);
        check("rsten_iaddr", 32'(ia), 0);
        check("rsten_idata", 32'(id), 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        do_txn(0, 32'h3000_0014, 0, 4'hF);

        // Random traffic against the model.
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h30, 8'hFC};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [7:0]  o;
            o = offs[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) a = {24'h300001, o};
            else a = {24'h300000, o[7:2], 2'($urandom_range(0, 3))};
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        do_txn(0, 32'h3000_0014, 0, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
